// File: rtl/sample_readout_sequencer_if.sv
// Sample-RAM read port plus output word stream. The master is the sequencer;
// the slave is the RAM together with the downstream sink.
interface sample_readout_sequencer_if;
  logic [10:0] rd_address;
  logic [15:0] rd_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    output rd_address,
    input  rd_data,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last
  );

  modport slave (
    input  rd_address,
    output rd_data,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last
  );
endinterface

// File: rtl/sample_readout_sequencer.sv
// Streams one A-line of NSAMPLES words from the sample RAM into a valid/ready sink.
// Latency: first sample RD_LATENCY+1 cycles after start (header word: 1 cycle), then one word per cycle.
// Backpressure: RAM reads are credit-limited by output FIFO space, so out_ready stalls never drop words.
// Optional macro SAMPLE_READOUT_HEADER_EN prefixes each A-line with a 16-bit A-line counter word.
module sample_readout_sequencer #(
  parameter int NSAMPLES   = 1170,
  parameter int RD_LATENCY = 2
) (
  input  logic                              clock,
  input  logic                              sclr,
  input  logic                              start,
  sample_readout_sequencer_if.master        bus,
  output logic                              busy,
  output logic                              overrun
);
  localparam int          DEPTH     = RD_LATENCY + 2;
  localparam int          PW        = $clog2(DEPTH);
  localparam int          CW        = $clog2(DEPTH + 1);
  localparam logic [10:0] LAST_ADDR = 11'(NSAMPLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  typedef struct packed {
    logic        last;
    logic [15:0] dat;
  } word_t;

  state_t                state_q, state_d;
  logic [10:0]           rd_address_q, rd_address_d;
  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LATENCY-1:0] pipe_last_q, pipe_last_d;
  word_t                 mem_q [DEPTH];
  word_t                 mem_d [DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         occ_q, occ_d;
  logic [CW-1:0]         credit_q, credit_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  logic  accept, issue, issue_last, hdr_push, push, pop;
  word_t push_word, head;

`ifdef SAMPLE_READOUT_HEADER_EN
  logic [15:0] aline_q, aline_d;
  assign hdr_push = accept;
`else
  assign hdr_push = 1'b0;
`endif

  assign head           = mem_q[rptr_q];
  assign bus.out_valid  = (occ_q != '0);
  assign bus.out_data   = head.dat;
  assign bus.out_last   = (occ_q != '0) && head.last;
  assign bus.rd_address = rd_address_q;
  assign busy           = busy_q;
  assign overrun        = overrun_q;

  always_comb begin
    state_d      = state_q;
    rd_address_d = rd_address_q;
    overrun_d    = overrun_q;
    mem_d        = mem_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    pipe_vld_d   = pipe_vld_q;
    pipe_last_d  = pipe_last_q;
    push         = 1'b0;
    push_word    = '0;
`ifdef SAMPLE_READOUT_HEADER_EN
    aline_d      = aline_q;
`endif

    // Address 0 is already on the bus while idle, so the start cycle itself issues it.
    accept     = start && (state_q == S_IDLE);
    pop        = (occ_q != '0) && bus.out_ready;
    issue      = accept || ((state_q == S_ISSUE) && (credit_q < CW'(DEPTH)));
    issue_last = issue && (rd_address_q == LAST_ADDR);

    pipe_vld_d[0]  = issue;
    pipe_last_d[0] = issue_last;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
    end

    // A returning read and a header push never coincide: the pipe is empty while idle.
    if (pipe_vld_q[RD_LATENCY-1]) begin
      push           = 1'b1;
      push_word.last = pipe_last_q[RD_LATENCY-1];
      push_word.dat  = bus.rd_data;
    end
`ifdef SAMPLE_READOUT_HEADER_EN
    else if (hdr_push) begin
      push           = 1'b1;
      push_word.last = 1'b0;
      push_word.dat  = aline_q;
    end
`endif

    if (push) begin
      mem_d[wptr_q] = push_word;
      wptr_d        = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    end
    occ_d    = occ_q + CW'(push) - CW'(pop);
    credit_d = credit_q + CW'(issue) + CW'(hdr_push) - CW'(pop);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (issue_last) begin
            state_d = S_DRAIN;
          end else begin
            state_d      = S_ISSUE;
            rd_address_d = 11'd1;
          end
        end
      end
      S_ISSUE: begin
        if (issue) begin
          if (issue_last) begin
            state_d      = S_DRAIN;
            rd_address_d = '0;
          end else begin
            rd_address_d = rd_address_q + 11'd1;
          end
        end
      end
      S_DRAIN: begin
        if (pop && head.last) begin
          state_d = S_IDLE;
`ifdef SAMPLE_READOUT_HEADER_EN
          aline_d = aline_q + 16'd1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q      <= S_IDLE;
      rd_address_q <= '0;
      pipe_vld_q   <= '0;
      pipe_last_q  <= '0;
      mem_q        <= '{default: '0};
      wptr_q       <= '0;
      rptr_q       <= '0;
      occ_q        <= '0;
      credit_q     <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SAMPLE_READOUT_HEADER_EN
      aline_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rd_address_q <= rd_address_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_last_q  <= pipe_last_d;
      mem_q        <= mem_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      occ_q        <= occ_d;
      credit_q     <= credit_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
`ifdef SAMPLE_READOUT_HEADER_EN
      aline_q      <= aline_d;
`endif
    end
  end
endmodule

// File: tb/tb_sample_readout_sequencer.sv
// Directed bench: main instance NSAMPLES=8/RD_LATENCY=2, corner instance NSAMPLES=1/RD_LATENCY=4.
// Both RAM models return address+0x100 with the instance's read latency.
module tb_sample_readout_sequencer;
`ifdef SAMPLE_READOUT_HEADER_EN
  localparam int HW = 1;
`else
  localparam int HW = 0;
`endif

  logic clock = 1'b0;
  logic sclr, start, start1;
  logic busy, overrun, busy1, overrun1;

  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [15:0] hdr;
  int          got;
  logic        done, stalled, prev_last;
  logic [15:0] prev_dat;

  sample_readout_sequencer_if bus0 ();
  sample_readout_sequencer_if bus1 ();

  sample_readout_sequencer #(.NSAMPLES(8), .RD_LATENCY(2)) dut (
    .clock(clock), .sclr(sclr), .start(start), .bus(bus0), .busy(busy), .overrun(overrun)
  );

  sample_readout_sequencer #(.NSAMPLES(1), .RD_LATENCY(4)) dut1 (
    .clock(clock), .sclr(sclr), .start(start1), .bus(bus1), .busy(busy1), .overrun(overrun1)
  );

  always #5 clock = ~clock;

  logic [10:0] ram0_q [2];
  logic [10:0] ram1_q [4];
  always @(posedge clock) begin
    ram0_q[0] <= bus0.rd_address;
    ram0_q[1] <= ram0_q[0];
    ram1_q[0] <= bus1.rd_address;
    for (int i = 1; i < 4; i++) ram1_q[i] <= ram1_q[i-1];
  end
  assign bus0.rd_data = 16'h0100 + {5'd0, ram0_q[1]};
  assign bus1.rd_data = 16'h0100 + {5'd0, ram1_q[3]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One A-line with out_ready=1; start at cycle 0, optional extra start at cycle 'extra'.
  task automatic line_rdy1(input int extra, input logic [15:0] h, input logic ovr_before);
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      start = (c == 0) || (c == extra);
      if (c == 0) chk("busy_c0", busy, 0);
      if (c == 1) chk("busy_c1", busy, 1);
      if (c == 2) chk("valid_c2", bus0.out_valid, 0);
`ifdef SAMPLE_READOUT_HEADER_EN
      if (c == 1) begin
        chk("hdr_valid", bus0.out_valid, 1);
        chk("hdr_data", bus0.out_data, h);
        chk("hdr_last", bus0.out_last, 0);
      end
`else
      if (c == 1) chk($sformatf("valid_c1_h%0h", h), bus0.out_valid, 0);
`endif
      if (c >= 3 && c <= 10) begin
        chk($sformatf("valid_c%0d", c), bus0.out_valid, 1);
        chk($sformatf("data_c%0d", c), bus0.out_data, 32'h100 + 32'(c - 3));
        chk($sformatf("last_c%0d", c), bus0.out_last, (c == 10));
        chk($sformatf("busy_c%0d", c), busy, 1);
      end
      if (c >= 11) begin
        chk($sformatf("valid_c%0d", c), bus0.out_valid, 0);
        chk($sformatf("busy_c%0d", c), busy, 0);
      end
      if (extra >= 0 && c == extra) chk("ovr_before", overrun, ovr_before);
      if (extra >= 0 && c > extra) chk($sformatf("ovr_after_c%0d", c), overrun, 1);
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sclr = 1'b1; start = 1'b0; start1 = 1'b0;
    bus0.out_ready = 1'b1; bus1.out_ready = 1'b1;
    hdr = 16'd0;

    // Reset, with start held during the last reset cycle (must be ignored).
    @(negedge clock);
    @(negedge clock); start = 1'b1;
    @(negedge clock); sclr = 1'b0; start = 1'b0;
    chk("rst_valid", bus0.out_valid, 0);
    chk("rst_last", bus0.out_last, 0);
    chk("rst_data", bus0.out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_addr", bus0.rd_address, 0);
    repeat (4) @(negedge clock);
    chk("rst_start_ignored_busy", busy, 0);
    chk("rst_start_ignored_valid", bus0.out_valid, 0);

    // Basic A-line, out_ready held high.
    line_rdy1(-1, hdr, 1'b0);
    hdr++;

    // Stalling sink: out_ready pattern 1,0,0,1.
    got = 0; done = 1'b0; stalled = 1'b0; prev_dat = '0; prev_last = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clock);
      start = (cyc == 0);
      bus0.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (stalled) begin
        chk("stall_valid", bus0.out_valid, 1);
        chk("stall_data", bus0.out_data, prev_dat);
        chk("stall_last", bus0.out_last, prev_last);
      end
      if (bus0.out_valid && bus0.out_ready) begin
        chk($sformatf("stream_data_%0d", got), bus0.out_data,
            (got < HW) ? 32'(hdr) : 32'h100 + 32'(got - HW));
        chk($sformatf("stream_last_%0d", got), bus0.out_last, (got == 8 + HW - 1));
        got++;
        if (bus0.out_last) done = 1'b1;
      end
      stalled   = bus0.out_valid && !bus0.out_ready;
      prev_dat  = bus0.out_data;
      prev_last = bus0.out_last;
    end
    start = 1'b0;
    chk("stream_count", got, 8 + HW);
    bus0.out_ready = 1'b1;
    @(negedge clock);
    chk("stream_busy_end", busy, 0);
    hdr++;

    // Start while busy: overrun set and sticky, stream intact, next line normal.
    line_rdy1(5, hdr, 1'b0);
    hdr++;
    line_rdy1(-1, hdr, 1'b1);
    hdr++;
    chk("ovr_sticky", overrun, 1);

    // sclr mid-readout at cycle 4, new start at cycle 7.
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      start = (c == 0) || (c == 7);
      sclr  = (c == 4);
      if (c == 5) begin
        chk("sclr_valid", bus0.out_valid, 0);
        chk("sclr_last", bus0.out_last, 0);
        chk("sclr_data", bus0.out_data, 0);
        chk("sclr_busy", busy, 0);
        chk("sclr_overrun", overrun, 0);
        chk("sclr_addr", bus0.rd_address, 0);
      end
      if ((c >= 5 && c <= 7) || c == 9) chk($sformatf("sclr_nostale_c%0d", c), bus0.out_valid, 0);
`ifdef SAMPLE_READOUT_HEADER_EN
      if (c == 8) chk("sclr_hdr", bus0.out_data, 0);
`endif
      if (c >= 10 && c <= 17) begin
        chk($sformatf("sclr_valid_c%0d", c), bus0.out_valid, 1);
        chk($sformatf("sclr_data_c%0d", c), bus0.out_data, 32'h100 + 32'(c - 10));
        chk($sformatf("sclr_last_c%0d", c), bus0.out_last, (c == 17));
      end
      if (c == 18) begin
        chk("sclr_busy_end", busy, 0);
        chk("sclr_ovr_end", overrun, 0);
      end
    end
    start = 1'b0; sclr = 1'b0;
    hdr = 16'd1;

    // Start coincident with the final transfer is ignored and flags overrun.
    line_rdy1(10, hdr, 1'b0);

    // Single-sample A-line with RD_LATENCY=4.
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      start1 = (c == 0);
      chk($sformatf("n1_addr_c%0d", c), bus1.rd_address, 0);
`ifdef SAMPLE_READOUT_HEADER_EN
      if (c == 1) begin
        chk("n1_hdr_valid", bus1.out_valid, 1);
        chk("n1_hdr_data", bus1.out_data, 0);
        chk("n1_hdr_last", bus1.out_last, 0);
      end
      if (c >= 2 && c <= 4) chk($sformatf("n1_valid_c%0d", c), bus1.out_valid, 0);
`else
      if (c >= 1 && c <= 4) chk($sformatf("n1_valid_c%0d", c), bus1.out_valid, 0);
`endif
      if (c >= 1 && c <= 5) chk($sformatf("n1_busy_c%0d", c), busy1, 1);
      if (c == 5) begin
        chk("n1_valid", bus1.out_valid, 1);
        chk("n1_data", bus1.out_data, 16'h0100);
        chk("n1_last", bus1.out_last, 1);
      end
      if (c >= 6) begin
        chk($sformatf("n1_idle_valid_c%0d", c), bus1.out_valid, 0);
        chk($sformatf("n1_idle_busy_c%0d", c), busy1, 0);
      end
    end
    start1 = 1'b0;
    chk("n1_overrun", overrun1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
